// File: rtl/multiword_cmp_pkg.sv
// Shared types for the multi-word comparator: FSM state encoding, the
// registered verdict bundle and a helper that turns the frame decision
// (decided / gt) into a one-hot Equal/Greater/Less verdict.
// Optional feature macro used by the top: MULTIWORD_CMP_MISMATCH_CNT_EN.
package multiword_cmp_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    RESULT  = 1'b1
  } cmp_state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_result_t;

  // An undecided frame means every word pair matched, so it is Equal.
  function automatic cmp_result_t make_result(input logic decided, input logic gt);
    cmp_result_t r;
    r.eq = ~decided;
    r.gt = decided & gt;
    r.lt = decided & ~gt;
    return r;
  endfunction

  // Verdict bundle driven whenever no verdict is being presented.
  localparam cmp_result_t RESULT_NONE = '{eq: 1'b0, gt: 1'b0, lt: 1'b0};

endpackage : multiword_cmp_pkg

// File: rtl/multiword_comparator_word_cmp.sv
// Combinational single-word comparator: unsigned equality and greater-than
// of one A/B word pair. The top instantiates it once and reuses it for
// every word of the frame.
module word_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             eq_o,
  output logic             gt_o
);

  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i > b_i);

endmodule : word_cmp

// File: rtl/multiword_comparator.sv
// Multi-word comparator. Operands arrive most-significant word first, one
// A/B pair per accepted handshake; after WORDS words a registered
// Equal/Greater/Less verdict is presented until the consumer accepts it.
// The first unequal word pair decides the verdict; later pairs only count.
// Optional feature: define MULTIWORD_CMP_MISMATCH_CNT_EN to add the
// Mismatch output, the number of unequal word pairs in the frame.
module multiword_comparator
  import multiword_cmp_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int WORDS = 4,
  localparam int CNT_W = $clog2(WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Equal,
  output logic             Greater,
  output logic             Less
`ifdef MULTIWORD_CMP_MISMATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] Mismatch
`endif
);

  // Count value held just before the final word of a frame is accepted.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  cmp_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             gt_q, gt_d;
  cmp_result_t      res_q, res_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             eq_s;
  logic             gt_s;
  logic             accept_s;
  logic             handshake_s;
  logic             last_word_s;

  word_cmp #(
    .WIDTH (WIDTH)
  ) u_word_cmp (
    .a_i  (A),
    .b_i  (B),
    .eq_o (eq_s),
    .gt_o (gt_s)
  );

  assign accept_s    = in_valid & in_ready_q;
  assign handshake_s = out_valid_q & out_ready;
  assign last_word_s = (cnt_q == LAST_CNT);

  // Frame FSM: collect words, fold in the first difference, present verdict.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    decided_d   = decided_q;
    gt_d        = gt_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      COLLECT: begin
        if (accept_s) begin
          cnt_d = cnt_q + CNT_ONE;
          // Only the most significant differing word decides the order.
          if (!decided_q && !eq_s) begin
            decided_d = 1'b1;
            gt_d      = gt_s;
          end else begin
            decided_d = decided_q;
            gt_d      = gt_q;
          end
          if (last_word_s) begin
            state_d     = RESULT;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            res_d       = make_result(decided_d, gt_d);
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end

      RESULT: begin
        // The handshake cycle only retires the verdict; no word is taken.
        if (handshake_s) begin
          state_d     = COLLECT;
          cnt_d       = '0;
          decided_d   = 1'b0;
          gt_d        = 1'b0;
          res_d       = RESULT_NONE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = RESULT;
        end
      end

      default: begin
        state_d     = COLLECT;
        cnt_d       = '0;
        decided_d   = 1'b0;
        gt_d        = 1'b0;
        res_d       = RESULT_NONE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // Frame state and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      decided_q   <= 1'b0;
      gt_q        <= 1'b0;
      res_q       <= RESULT_NONE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      decided_q   <= decided_d;
      gt_q        <= gt_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Equal     = res_q.eq;
  assign Greater   = res_q.gt;
  assign Less      = res_q.lt;

`ifdef MULTIWORD_CMP_MISMATCH_CNT_EN
  logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;
  logic [CNT_W-1:0] mm_out_q, mm_out_d;

  // Running count of unequal pairs; published together with the verdict.
  always_comb begin
    mm_cnt_d = mm_cnt_q;
    mm_out_d = mm_out_q;
    case (state_q)
      COLLECT: begin
        if (accept_s) begin
          if (!eq_s) begin
            mm_cnt_d = mm_cnt_q + CNT_ONE;
          end else begin
            mm_cnt_d = mm_cnt_q;
          end
          if (last_word_s) begin
            mm_out_d = mm_cnt_d;
          end else begin
            mm_out_d = mm_out_q;
          end
        end else begin
          mm_cnt_d = mm_cnt_q;
        end
      end
      RESULT: begin
        if (handshake_s) begin
          mm_cnt_d = '0;
          mm_out_d = '0;
        end else begin
          mm_out_d = mm_out_q;
        end
      end
      default: begin
        mm_cnt_d = '0;
        mm_out_d = '0;
      end
    endcase
  end

  // Mismatch counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mm_cnt_q <= '0;
      mm_out_q <= '0;
    end else begin
      mm_cnt_q <= mm_cnt_d;
      mm_out_q <= mm_out_d;
    end
  end

  assign Mismatch = mm_out_q;
`endif

endmodule : multiword_comparator

// File: tb/tb_multiword_comparator.sv
// Directed bench for multiword_comparator (WIDTH=4, WORDS=4). Table-driven
// frames plus hand-written sequences for back-to-back frames, input gaps,
// output back-pressure and mid-frame reset. Mismatch is checked only when
// MULTIWORD_CMP_MISMATCH_CNT_EN is defined.
module tb_multiword_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A;
  logic [3:0] B;
  logic       out_valid;
  logic       out_ready;
  logic       Equal;
  logic       Greater;
  logic       Less;
`ifdef MULTIWORD_CMP_MISMATCH_CNT_EN
  logic [2:0] Mismatch;
`endif

  int total = 0;
  int bad   = 0;

  multiword_comparator #(.WIDTH(4), .WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Equal     (Equal),
    .Greater   (Greater),
    .Less      (Less)
`ifdef MULTIWORD_CMP_MISMATCH_CNT_EN
    ,
    .Mismatch  (Mismatch)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;   // MS word in [15:12]
    logic [15:0] b;
    logic        eq;
    logic        gt;
    logic        lt;
    logic [2:0]  mm;
  } frame_t;

  frame_t vec [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one word pair and return just after the edge that accepts it.
  task automatic push(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    A = a;
    B = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Check a presented verdict at the current (negedge) sample point.
  task automatic chk_result(input string tag, input logic eq, input logic gt,
                            input logic lt, input logic [2:0] mm);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".in_ready"},  32'(in_ready),  32'd0);
    chk({tag, ".Equal"},     32'(Equal),     32'(eq));
    chk({tag, ".Greater"},   32'(Greater),   32'(gt));
    chk({tag, ".Less"},      32'(Less),      32'(lt));
`ifdef MULTIWORD_CMP_MISMATCH_CNT_EN
    chk({tag, ".Mismatch"},  32'(Mismatch),  32'(mm));
`else
    if (mm === 3'bxxx) chk({tag, ".mm_unused"}, 32'(mm), 32'd0);
`endif
  endtask

  // Check the idle condition: no verdict shown, ready for words.
  task automatic chk_idle(input string tag);
    chk({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".idle_ready"}, 32'(in_ready),  32'd1);
    chk({tag, ".idle_eq"},    32'(Equal),     32'd0);
    chk({tag, ".idle_gt"},    32'(Greater),   32'd0);
    chk({tag, ".idle_lt"},    32'(Less),      32'd0);
  endtask

  initial begin
    // {A, B, Equal, Greater, Less, Mismatch}
    vec[0] = '{16'h9300, 16'h9300, 1'b1, 1'b0, 1'b0, 3'd0};
    vec[1] = '{16'h9350, 16'h92FF, 1'b0, 1'b1, 1'b0, 3'd3};
    vec[2] = '{16'hFFFF, 16'hF0F1, 1'b0, 1'b1, 1'b0, 3'd2};
    vec[3] = '{16'h5554, 16'h5555, 1'b0, 1'b0, 1'b1, 3'd1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = 4'h0;
    B         = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
`ifdef MULTIWORD_CMP_MISMATCH_CNT_EN
    chk("reset.Mismatch", 32'(Mismatch), 32'd0);
`endif
    rst = 1'b0;

    // Table-driven frames, one-cycle verdict with out_ready held high.
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < 4; w++) begin
        push(vec[i].a[15 - 4*w -: 4], vec[i].b[15 - 4*w -: 4]);
        if (w < 3) chk($sformatf("vec%0d.w%0d_busy", i, w), 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      chk_result($sformatf("vec%0d", i), vec[i].eq, vec[i].gt, vec[i].lt, vec[i].mm);
      @(negedge clk);
      chk_idle($sformatf("vec%0d", i));
    end

    // Less frame followed immediately by an Equal frame; the first word of the
    // second frame is offered during the handshake cycle and must wait.
    push(4'h1, 4'h2);
    push(4'h0, 4'h0);
    push(4'h0, 4'h0);
    push(4'h0, 4'h0);
    @(negedge clk);
    chk_result("b2b_less", 1'b0, 1'b0, 1'b1, 3'd1);
    in_valid = 1'b1;
    A = 4'hF;
    B = 4'hF;
    @(negedge clk);
    chk_idle("b2b_hs");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    push(4'hF, 4'hF);
    push(4'hF, 4'hF);
    chk("b2b.w3_busy", 32'(out_valid), 32'd0);
    push(4'hF, 4'hF);
    @(negedge clk);
    chk_result("b2b_equal", 1'b1, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    chk_idle("b2b_equal");

    // Input gap mid-frame and output back-pressure in RESULT.
    push(4'h2, 4'h2);
    push(4'h7, 4'h6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("gap%0d.valid", k), 32'(out_valid), 32'd0);
      chk($sformatf("gap%0d.ready", k), 32'(in_ready),  32'd1);
    end
    push(4'h1, 4'h9);
    out_ready = 1'b0;
    push(4'h0, 4'h9);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_result($sformatf("hold%0d", k), 1'b0, 1'b1, 1'b0, 3'd3);
      in_valid = 1'b1;
      A = 4'h0;
      B = 4'hF;
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk_idle("hold_release");

    // Reset after two accepted words discards the partial frame.
    push(4'h8, 4'h1);
    push(4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle("midrst");
    push(4'h3, 4'h3);
    push(4'h3, 4'h3);
    chk("midrst.w1_busy", 32'(out_valid), 32'd0);
    push(4'h3, 4'h3);
    chk("midrst.w2_busy", 32'(out_valid), 32'd0);
    push(4'h3, 4'h4);
    @(negedge clk);
    chk_result("midrst", 1'b0, 1'b0, 1'b1, 3'd1);
    @(negedge clk);
    chk_idle("midrst_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_multiword_comparator
